// File: rtl/wake_io_ctrl.sv
// Pad-side wake controller: input synchronisers, merged wake output with
// stretch/latch/toggle modes, sticky per-channel status, irq and a saturating
// event counter for firmware.
module wake_io_ctrl #(
    parameter int unsigned NUM_IN      = 2,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned NUM_WAKE    = 1,
    parameter int unsigned HOLD_BW     = 16,
    parameter int unsigned CNT_BW      = 8
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic [NUM_IN-1:0]   pad_in_i,
    output logic [NUM_IN-1:0]   pad_in_sync_o,
    input  logic [NUM_WAKE-1:0] wake_i,
    input  logic [NUM_WAKE-1:0] chan_en_i,
    input  logic [1:0]          mode_i,
    input  logic [HOLD_BW-1:0]  hold_cycles_i,
    input  logic                clear_i,
    output logic                wake_o,
    output logic [NUM_WAKE-1:0] status_o,
    output logic                irq_o,
    output logic [CNT_BW-1:0]   event_cnt_o
);

    localparam logic [1:0] ModeOff     = 2'b00;
    localparam logic [1:0] ModeStretch = 2'b01;
    localparam logic [1:0] ModeLatch   = 2'b10;
    localparam logic [1:0] ModeToggle  = 2'b11;

    typedef enum logic [1:0] {StIdle, StHold, StLatch} state_e;

    logic [SYNC_STAGES-1:0][NUM_IN-1:0] sync_q;
    state_e                             state_q, state_d;
    logic [HOLD_BW-1:0]                 cnt_q, cnt_d;
    logic                               tog_q, tog_d;
    logic                               wake_q, wake_d;
    logic [1:0]                         mode_q;
    logic [NUM_WAKE-1:0]                status_q, status_d;
    logic                               irq_q;
    logic [CNT_BW-1:0]                  ev_cnt_q, ev_cnt_d;

    logic [NUM_WAKE-1:0] ev_k;
    logic                ev;
    logic                mode_chg;
    logic [HOLD_BW-1:0]  hold_load;

    assign ev_k      = wake_i & chan_en_i & {NUM_WAKE{mode_i != ModeOff}};
    assign ev        = |ev_k;
    assign mode_chg  = (mode_i != mode_q);
    // A zero stretch length behaves as one cycle.
    assign hold_load = (hold_cycles_i == '0) ? '0 : hold_cycles_i - HOLD_BW'(1);

    // Pad input synchroniser chains; stage 0 samples the raw pad.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pad_in_i};
        end
    end

    // Wake FSM next state, hold counter, toggle flop and wake output.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tog_d   = tog_q;
        wake_d  = 1'b0;
        if (mode_chg || mode_i == ModeOff) begin
            // Events in a mode-change cycle still count but never drive the pad.
            state_d = StIdle;
            cnt_d   = '0;
            tog_d   = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (mode_i == ModeStretch && ev) begin
                        state_d = StHold;
                        cnt_d   = hold_load;
                        wake_d  = 1'b1;
                    end else if (mode_i == ModeLatch && ev) begin
                        state_d = StLatch;
                        wake_d  = 1'b1;
                    end else if (mode_i == ModeToggle) begin
                        if (ev) begin
                            tog_d = clear_i ? 1'b1 : ~tog_q;
                        end else if (clear_i) begin
                            tog_d = 1'b0;
                        end
                        wake_d = tog_d;
                    end
                end
                StHold: begin
                    if (ev) begin
                        cnt_d  = hold_load;
                        wake_d = 1'b1;
                    end else if (cnt_q == '0) begin
                        state_d = StIdle;
                    end else begin
                        cnt_d  = cnt_q - HOLD_BW'(1);
                        wake_d = 1'b1;
                    end
                end
                StLatch: begin
                    if (clear_i && !ev) begin
                        state_d = StIdle;
                    end else begin
                        wake_d = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Sticky status (set beats clear) and saturating event counter.
    always_comb begin
        status_d = (clear_i ? '0 : status_q) | ev_k;
        ev_cnt_d = ev_cnt_q;
        if (clear_i) begin
            ev_cnt_d = ev ? CNT_BW'(1) : '0;
        end else if (ev && ev_cnt_q != '1) begin
            ev_cnt_d = ev_cnt_q + CNT_BW'(1);
        end
    end

    // State registers for FSM, status, irq and counter.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            tog_q    <= 1'b0;
            wake_q   <= 1'b0;
            mode_q   <= ModeOff;
            status_q <= '0;
            irq_q    <= 1'b0;
            ev_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            tog_q    <= tog_d;
            wake_q   <= wake_d;
            mode_q   <= mode_i;
            status_q <= status_d;
            irq_q    <= |status_q;
            ev_cnt_q <= ev_cnt_d;
        end
    end

    assign pad_in_sync_o = sync_q[SYNC_STAGES-1];
    assign wake_o        = wake_q;
    assign status_o      = status_q;
    assign irq_o         = irq_q;
    assign event_cnt_o   = ev_cnt_q;

endmodule
